// File: rtl/apb_timer_slave.sv
// apb_timer_slave: zero-wait-state APB peripheral with a prescaled 32-bit
// down-counter, optional auto-reload and a level interrupt.
//
// Handshake: a transfer is one setup cycle (psel=1, penable=0) followed by
// one access cycle (psel=1, penable=1). Reads capture prdata at the edge
// that ends the setup cycle. Writes commit at the edge that ends the access
// cycle, and only when the FSM is in SETUP, so each transfer commits once.
// penable seen outside SETUP is ignored.
module apb_timer_slave #(
   parameter int          PSC_W      = 8,
   parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        irq,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_t;

   localparam logic [1:0] A_CTRL  = 2'd0;
   localparam logic [1:0] A_LOAD  = 2'd1;
   localparam logic [1:0] A_COUNT = 2'd2;
   localparam logic [1:0] A_STAT  = 2'd3;

   apb_state_t       state, state_nxt;
   logic             wr_commit, rd_load;
   logic [1:0]       addr;
   logic             ctrl_en, ctrl_reload, ctrl_ie;
   logic [PSC_W-1:0] ctrl_psc;
   logic [PSC_W-1:0] pcnt;
   logic [31:0]      load_q, count_q;
   logic             exp_q;
   logic             tick, expire;
   logic             ctrl_wr, load_wr, stat_clr;
   logic [31:0]      rd_data;
   logic             unused_addr_bits;

   assign addr             = paddr[3:2];
   assign unused_addr_bits = ^{paddr[31:4], paddr[1:0]};
   assign dbg_state        = state;

   // APB state register
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // APB next-state and transfer strobes
   always_comb begin
      state_nxt = state;
      wr_commit = 1'b0;
      rd_load   = psel & ~penable & ~pwrite;
      case (state)
         ST_IDLE: begin
            if (psel && !penable) state_nxt = ST_SETUP;
         end
         ST_SETUP: begin
            if (!psel) state_nxt = ST_IDLE;
            else if (penable) begin
               state_nxt = ST_ACCESS;
               wr_commit = pwrite;
            end
         end
         ST_ACCESS: begin
            if (psel && !penable) state_nxt = ST_SETUP;
            else                  state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // a LOAD write restarts the count, so it suppresses any tick/expiry that edge
   assign ctrl_wr  = wr_commit & (addr == A_CTRL);
   assign load_wr  = wr_commit & (addr == A_LOAD);
   assign stat_clr = wr_commit & (addr == A_STAT) & pwdata[0];
   assign tick     = ctrl_en & (pcnt == ctrl_psc);
   assign expire   = tick & (count_q == 32'd0) & ~load_wr;
   assign irq      = exp_q & ctrl_ie;

   // control register; a CTRL write overrides the one-shot EN clear
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         ctrl_en     <= 1'b0;
         ctrl_reload <= 1'b0;
         ctrl_ie     <= 1'b0;
         ctrl_psc    <= '0;
      end else if (ctrl_wr) begin
         ctrl_en     <= pwdata[0];
         ctrl_reload <= pwdata[1];
         ctrl_ie     <= pwdata[2];
         ctrl_psc    <= pwdata[4 +: PSC_W];
      end else if (expire && !ctrl_reload) begin
         ctrl_en     <= 1'b0;
      end
   end

   // reload value
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset)       load_q <= RESET_LOAD;
      else if (load_wr) load_q <= pwdata;
   end

   // prescaler: held at 0 while disabled, wraps to 0 on every tick
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset)                          pcnt <= '0;
      else if (!ctrl_en || load_wr || tick) pcnt <= '0;
      else                                 pcnt <= pcnt + 1'b1;
   end

   // down-counter with restart on LOAD write and optional reload on expiry
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset)                count_q <= 32'd0;
      else if (load_wr)          count_q <= pwdata;
      else if (tick) begin
         if (count_q != 32'd0)   count_q <= count_q - 32'd1;
         else if (ctrl_reload)   count_q <= load_q;
      end
   end

   // expiry flag; a set in the same cycle as a W1C wins
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset)        exp_q <= 1'b0;
      else if (expire)   exp_q <= 1'b1;
      else if (stat_clr) exp_q <= 1'b0;
   end

   // read mux, unmapped bits are zero
   always_comb begin
      rd_data = 32'd0;
      case (addr)
         A_CTRL:  rd_data = {{(28 - PSC_W){1'b0}}, ctrl_psc, 1'b0,
                             ctrl_ie, ctrl_reload, ctrl_en};
         A_LOAD:  rd_data = load_q;
         A_COUNT: rd_data = count_q;
         A_STAT:  rd_data = {31'd0, exp_q};
         default: rd_data = 32'd0;
      endcase
   end

   // read data captured at the end of the setup phase and held until the next one
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset)       prdata <= 32'd0;
      else if (rd_load) prdata <= rd_data;
   end

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a
// transaction-level model of the timer.
module tb_apb_timer_slave;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata;
   logic        irq;
   logic [1:0]  dbg_state;

   int n_assert = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   apb_timer_slave #(.PSC_W(8), .RESET_LOAD(32'hFFFF_FFFF)) dut (
      .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .irq(irq), .dbg_state(dbg_state)
   );

   // clock
   always #5 hclk = ~hclk;

   // ---------------- reference model ----------------
   logic        m_en, m_reload, m_ie;
   logic [7:0]  m_psc, m_pcnt;
   logic [31:0] m_load, m_count, m_prdata;
   logic        m_exp, m_in_setup;
   logic        m_wr, m_tick, m_ld, m_expire;
   logic [1:0]  m_a;
   logic [31:0] m_next_count;

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return 32'(m_psc) * 16 + 32'(m_ie) * 4 + 32'(m_reload) * 2 + 32'(m_en);
         2'd1:    return m_load;
         2'd2:    return m_count;
         default: return 32'(m_exp);
      endcase
   endfunction

   // a transfer is in its access phase when the previous cycle was a setup cycle
   always @(posedge hclk or posedge hreset) begin : model
      if (hreset) begin
         m_en = 0; m_reload = 0; m_ie = 0; m_psc = 0; m_pcnt = 0;
         m_load = 32'hFFFF_FFFF; m_count = 0; m_exp = 0;
         m_prdata = 0; m_in_setup = 0;
      end else begin
         m_a      = paddr[3:2];
         m_wr     = m_in_setup && psel && penable && pwrite;
         m_ld     = m_wr && (m_a == 2'd1);
         m_tick   = m_en && (m_pcnt == m_psc);
         m_expire = m_tick && (m_count == 0) && !m_ld;
         if (psel && !penable && !pwrite) m_prdata = m_read(m_a);
         if (m_ld)                 m_next_count = pwdata;
         else if (!m_tick)         m_next_count = m_count;
         else if (m_count != 0)    m_next_count = m_count - 1;
         else if (m_reload)        m_next_count = m_load;
         else                      m_next_count = 0;
         if (!m_en || m_ld || m_tick) m_pcnt = 0;
         else                         m_pcnt = m_pcnt + 1;
         if (m_expire)                               m_exp = 1;
         else if (m_wr && m_a == 2'd3 && pwdata[0])  m_exp = 0;
         if (m_wr && m_a == 2'd0) begin
            m_en = pwdata[0]; m_reload = pwdata[1]; m_ie = pwdata[2]; m_psc = pwdata[11:4];
         end else if (m_expire && !m_reload) begin
            m_en = 0;
         end
         if (m_ld) m_load = pwdata;
         m_count    = m_next_count;
         m_in_setup = psel && !penable;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // every-cycle comparison of outputs against the model
   always @(negedge hclk) begin
      if (cmp_en) begin
         check("prdata_vs_model", prdata, m_prdata);
         check("irq_vs_model", {31'd0, irq}, {31'd0, m_exp & m_ie});
      end
   end

   // ---------------- drivers ----------------
   task automatic apb_setup(input logic [31:0] a, input logic w, input logic [31:0] d);
      @(posedge hclk); #1;
      psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
   endtask

   task automatic apb_access();
      @(posedge hclk); #1;
      penable = 1;
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      apb_setup(a, 1'b1, d);
      apb_access();
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      apb_setup(a, 1'b0, $urandom);
      apb_access();
      @(negedge hclk);
      d = prdata;
   endtask

   task automatic apb_idle();
      @(posedge hclk); #1;
      psel = 0; penable = 0; pwrite = 0;
   endtask

   task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      apb_read(a, d);
      check(name, d, exp);
   endtask

   // counts edges until irq is seen high, budget+1 if it never rises
   task automatic wait_irq(input int budget, output int n);
      n = budget + 1;
      for (int k = 1; k <= budget; k++) begin
         @(posedge hclk); #1;
         if (irq) begin n = k; break; end
      end
   endtask

   task automatic pulse_reset();
      #1 hreset = 1;
      psel = 0; penable = 0; pwrite = 0;
      repeat (2) @(posedge hclk);
      #1 hreset = 0;
   endtask

   // ---------------- stimulus ----------------
   int          n;
   logic [31:0] d, a;

   initial begin
      hreset = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      repeat (3) @(posedge hclk);
      #1 hreset = 0;
      cmp_en = 1;

      // reset values
      read_check("rst_ctrl", 32'h0, 32'h0);
      read_check("rst_load", 32'h4, 32'hFFFF_FFFF);
      read_check("rst_count", 32'h8, 32'h0);
      read_check("rst_stat", 32'hC, 32'h0);

      // reset while counting, with irq high and prdata nonzero, mid-transfer
      apb_write(32'h4, 32'd2);
      apb_write(32'h0, 32'h7);
      apb_idle();
      repeat (6) @(posedge hclk);
      read_check("pre_rst_load", 32'h4, 32'd2);
      apb_setup(32'h4, 1'b1, 32'h77);
      apb_access();
      #2 hreset = 1;
      @(negedge hclk);
      check("rst_prdata", prdata, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'h0);
      psel = 0; penable = 0; pwrite = 0;
      @(posedge hclk); #1 hreset = 0;
      read_check("rst2_ctrl", 32'h0, 32'h0);
      read_check("rst2_load", 32'h4, 32'hFFFF_FFFF);
      read_check("rst2_count", 32'h8, 32'h0);
      read_check("rst2_stat", 32'hC, 32'h0);

      // one-shot from 5 with PSC=0
      apb_write(32'h4, 32'd5);
      apb_write(32'h0, 32'h1);
      read_check("oneshot_first", 32'h8, 32'd5);
      apb_idle();
      repeat (10) @(posedge hclk);
      read_check("oneshot_count", 32'h8, 32'd0);
      read_check("oneshot_stat", 32'hC, 32'd1);
      read_check("oneshot_en_clr", 32'h0, 32'd0);

      // auto-reload with interrupt
      apb_write(32'hC, 32'd1);
      apb_write(32'h4, 32'd3);
      apb_write(32'h0, 32'h7);
      apb_idle();
      wait_irq(20, n);
      check("reload_irq_ticks", n, 4);
      read_check("reload_count", 32'h8, 32'd2);
      apb_write(32'h0, 32'h6);
      apb_idle();
      check("irq_before_w1c", {31'd0, irq}, 32'd1);
      apb_write(32'hC, 32'd1);
      apb_idle();
      check("irq_after_w1c", {31'd0, irq}, 32'd0);

      // prescaled one-shot: LOAD=2, PSC=3
      apb_write(32'h4, 32'd2);
      apb_write(32'h0, 32'h35);
      apb_idle();
      wait_irq(40, n);
      check("psc_cycles_to_exp", n, 12);
      apb_write(32'h0, 32'h0);
      apb_write(32'hC, 32'd1);

      // W1C on an expiry edge, then LOAD write on a tick edge (PSC=7, LOAD=0)
      apb_write(32'h4, 32'd0);
      apb_write(32'h0, 32'h77);
      apb_idle();
      repeat (13) @(posedge hclk);
      apb_write(32'hC, 32'd1);
      apb_idle();
      check("w1c_vs_expire", {31'd0, irq}, 32'd1);
      repeat (5) @(posedge hclk);
      apb_write(32'h4, 32'h1234);
      apb_idle();
      read_check("load_vs_tick", 32'h8, 32'h1234);
      apb_write(32'h0, 32'h0);
      apb_write(32'hC, 32'd1);
      apb_idle();

      // back-to-back transfers, COUNT write ignored, aliased address, stray penable
      apb_write(32'h4, 32'hA5A5_0000);
      apb_write(32'h0, 32'h6);
      apb_idle();
      read_check("b2b_ctrl", 32'h0, 32'h6);
      read_check("b2b_load_alias", 32'hFFFF_FFF5, 32'hA5A5_0000);
      apb_write(32'h8, 32'hDEAD);
      read_check("count_ro", 32'h8, 32'hA5A5_0000);
      apb_idle();
      @(posedge hclk); #1;
      psel = 1; penable = 1; pwrite = 1; paddr = 32'h4; pwdata = 32'h1111;
      apb_idle();
      read_check("stray_penable", 32'h4, 32'hA5A5_0000);
      apb_idle();

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         int op;
         op = $urandom_range(0, 9);
         a  = $urandom;
         case (a[3:2])
            2'd0:    d = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 3)) << 4)
                         | 32'($urandom_range(0, 7));
            2'd1:    d = 32'($urandom_range(0, 12));
            default: d = $urandom;
         endcase
         if (i == 150) begin
            apb_setup(a, 1'b1, d);
            pulse_reset();
         end else if (op <= 3) begin
            apb_write(a, d);
         end else if (op <= 6) begin
            apb_read(a, d);
         end else if (op == 7) begin
            apb_idle();
            repeat ($urandom_range(0, 5)) @(posedge hclk);
         end else if (op == 8) begin
            apb_idle();
            @(posedge hclk); #1;
            psel = 1; penable = 1; pwrite = 1'($urandom_range(0, 1)); paddr = a; pwdata = d;
            apb_idle();
         end else begin
            apb_setup(a, 1'($urandom_range(0, 1)), d);
            repeat ($urandom_range(1, 3)) @(posedge hclk);
            #1;
            apb_access();
         end
      end
      apb_idle();
      repeat (4) @(posedge hclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
